action_reset_sequencer: RTL and testbench

//   Parametrised multi-domain reset sequencer for action entities.
//   - Holds all domains in reset for a duty cycle, then releases them in

---
 rtl/action_reset_sequencer_pkg.sv | 12 +
 rtl/action_reset_down_counter.sv | 25 ++
 rtl/action_reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_action_reset_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/action_reset_sequencer_pkg.sv
// rtl/action_reset_sequencer_pkg.sv - state encodings shared by the action reset sequencer
package action_reset_sequencer_pkg;

    localparam int StateWidth = 3;

    localparam logic [StateWidth-1:0] StHold     = 3'd0;
    localparam logic [StateWidth-1:0] StRelease  = 3'd1;
    localparam logic [StateWidth-1:0] StDone     = 3'd2;
    localparam logic [StateWidth-1:0] StShutdown = 3'd3;
    localparam logic [StateWidth-1:0] StFault    = 3'd4;

endpackage

// File: rtl/action_reset_down_counter.sv
// rtl/action_reset_down_counter.sv - loadable down-counter that saturates at zero
module action_reset_down_counter #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic [Width-1:0] loadValue,
    input  logic             enable,
    output logic             zero
);

    logic [Width-1:0] count;

    // load has priority so a restart always reseeds the count
    always_ff @(posedge clk) begin
        if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/action_reset_sequencer.sv
// rtl/action_reset_sequencer.sv - ordered multi-domain reset release with timeout and soft restart
module action_reset_sequencer
    import action_reset_sequencer_pkg::*;
#(
    parameter int ResetDomains       = 4,
    parameter int DomainIndexSize    = 2,
    parameter int ResetDutyCycle     = 15,
    parameter int ResetCounterSize   = 4,
    parameter int ReadyTimeout       = 1024,
    parameter int TimeoutCounterSize = 11
) (
    input  logic                       clk,
    input  logic                       sysRstReq,
    output logic [ResetDomains-1:0]    domainRst,
    input  logic [ResetDomains-1:0]    domainRdy,
    input  logic [ResetDomains-1:0]    domainRstReq,
    output logic                       sysResetDone,
    output logic                       sysResetError,
    output logic [DomainIndexSize-1:0] errorDomain
);

    localparam logic [DomainIndexSize-1:0]    LastIdx        = DomainIndexSize'(ResetDomains - 1);
    localparam logic [ResetCounterSize-1:0]   DutyLoad       = ResetCounterSize'(ResetDutyCycle);
    localparam logic [TimeoutCounterSize-1:0] TimeoutLoad    = TimeoutCounterSize'(ReadyTimeout);
    localparam bit                            TimeoutEnabled = (ReadyTimeout != 0);

    // power-up values hold every domain in reset until the first sysRstReq
    logic [StateWidth-1:0]      state  = StHold;
    logic [ResetDomains-1:0]    rstReg = '1;

    logic [DomainIndexSize-1:0] idx;
    logic [DomainIndexSize-1:0] restartIdx;
    logic [DomainIndexSize-1:0] target;
    logic [DomainIndexSize-1:0] lowReq;
    logic [ResetDomains-1:0]    readyState;
    logic [ResetDomains-1:0]    rdyNext;
    logic [ResetDomains-1:0]    idxMask;
    logic [ResetDomains-1:0]    restartMask;
    logic                       curReady;
    logic                       dutyZero;
    logic                       timeoutZero;
    logic                       dutyLoadEn;
    logic                       dutyCountEn;
    logic                       timeoutLoadEn;
    logic                       timeoutCountEn;

    assign idxMask     = ResetDomains'(1) << idx;
    assign restartMask = ResetDomains'(1) << restartIdx;
    assign curReady    = |((readyState | domainRdy) & idxMask);
    // ready is only latched for domains that are out of reset
    assign rdyNext     = readyState | (domainRdy & ~rstReg);

    always_comb begin
        lowReq = '0;
        for (int i = ResetDomains - 1; i >= 0; i--) begin
            if (domainRstReq[i]) begin
                lowReq = DomainIndexSize'(i);
            end
        end
    end

    assign dutyLoadEn     = sysRstReq || ((state == StShutdown) && (idx == target));
    assign dutyCountEn    = (state == StHold);
    assign timeoutLoadEn  = sysRstReq || ((state == StHold) && dutyZero)
                            || ((state == StRelease) && curReady);
    assign timeoutCountEn = (state == StRelease) && !curReady;

    action_reset_down_counter #(
        .Width(ResetCounterSize)
    ) dutyCounter (
        .clk      (clk),
        .load     (dutyLoadEn),
        .loadValue(DutyLoad),
        .enable   (dutyCountEn),
        .zero     (dutyZero)
    );

    action_reset_down_counter #(
        .Width(TimeoutCounterSize)
    ) timeoutCounter (
        .clk      (clk),
        .load     (timeoutLoadEn),
        .loadValue(TimeoutLoad),
        .enable   (timeoutCountEn),
        .zero     (timeoutZero)
    );

    always_ff @(posedge clk) begin
        if (sysRstReq) begin
            state         <= StHold;
            rstReg        <= '1;
            readyState    <= '0;
            idx           <= '0;
            restartIdx    <= '0;
            target        <= '0;
            sysResetDone  <= 1'b0;
            sysResetError <= 1'b0;
            errorDomain   <= '0;
        end else begin
            readyState <= rdyNext;
            case (state)
                StHold: begin
                    if (dutyZero) begin
                        state  <= StRelease;
                        idx    <= restartIdx;
                        rstReg <= rstReg & ~restartMask;
                    end
                end
                StRelease: begin
                    if (curReady) begin
                        if (idx == LastIdx) begin
                            state        <= StDone;
                            sysResetDone <= 1'b1;
                        end else begin
                            idx    <= idx + DomainIndexSize'(1);
                            rstReg <= rstReg & ~(idxMask << 1);
                        end
                    end else if (TimeoutEnabled && timeoutZero) begin
                        state         <= StFault;
                        rstReg        <= '1;
                        sysResetError <= 1'b1;
                        errorDomain   <= idx;
                    end
                end
                StDone: begin
                    if (|domainRstReq) begin
                        state        <= StShutdown;
                        idx          <= LastIdx;
                        target       <= lowReq;
                        restartIdx   <= lowReq;
                        sysResetDone <= 1'b0;
                    end
                end
                StShutdown: begin
                    rstReg     <= rstReg | idxMask;
                    readyState <= rdyNext & ~idxMask;
                    if (idx == target) begin
                        state <= StHold;
                    end else begin
                        idx <= idx - DomainIndexSize'(1);
                    end
                end
                StFault: begin
                    rstReg        <= '1;
                    sysResetError <= 1'b1;
                    sysResetDone  <= 1'b0;
                end
                default: begin
                    state  <= StHold;
                    rstReg <= '1;
                end
            endcase
        end
    end

    assign domainRst = rstReg;

endmodule

// File: tb/tb_action_reset_sequencer.sv
// tb/tb_action_reset_sequencer.sv - randomized check of the reset sequencer against a timeline model
module tb_action_reset_sequencer;

    localparam int N   = 4;
    localparam int D   = 15;
    localparam int T   = 8;
    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       sysRstReq;
    logic [3:0] domainRst;
    logic [3:0] domainRdy;
    logic [3:0] domainRstReq;
    logic       sysResetDone;
    logic       sysResetError;
    logic [1:0] errorDomain;

    logic       sysRstReq1;
    logic [0:0] domainRst1;
    logic [0:0] domainRdy1;
    logic [0:0] domainRstReq1;
    logic       sysResetDone1;
    logic       sysResetError1;
    logic [0:0] errorDomain1;

    int total = 0;
    int bad   = 0;

    action_reset_sequencer #(
        .ResetDomains(4), .DomainIndexSize(2), .ResetDutyCycle(D), .ResetCounterSize(4),
        .ReadyTimeout(T), .TimeoutCounterSize(4)
    ) dut4 (
        .clk(clk), .sysRstReq(sysRstReq), .domainRst(domainRst), .domainRdy(domainRdy),
        .domainRstReq(domainRstReq), .sysResetDone(sysResetDone),
        .sysResetError(sysResetError), .errorDomain(errorDomain)
    );

    action_reset_sequencer #(
        .ResetDomains(1), .DomainIndexSize(1), .ResetDutyCycle(D), .ResetCounterSize(4),
        .ReadyTimeout(0), .TimeoutCounterSize(11)
    ) dut1 (
        .clk(clk), .sysRstReq(sysRstReq1), .domainRst(domainRst1), .domainRdy(domainRdy1),
        .domainRstReq(domainRstReq1), .sysResetDone(sysResetDone1),
        .sysResetError(sysResetError1), .errorDomain(errorDomain1)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: each domain's release edge follows from the previous one plus its ready delay;
    // edges are counted from the edge that samples sysRstReq.
    task automatic runIter(input int it);
        int rd1[4];
        int rd2[4];
        int rel1[4];
        int rel2[4];
        int set2[4];
        int done1, done2, fault, fIdx, s, kLow, r, endE, last;
        bit doSoft;
        logic [3:0] pat;
        logic [3:0] rstE;

        for (int m = 0; m < N; m++) begin
            rd1[m]  = ($urandom_range(0, 9) == 0) ? T + 2 : $urandom_range(1, 4);
            rd2[m]  = ($urandom_range(0, 9) == 0) ? T + 2 : $urandom_range(1, 4);
            rel1[m] = BIG;
            rel2[m] = BIG;
            set2[m] = BIG;
            if (it != 2 && it < 4) begin
                rd1[m] = 1;
                rd2[m] = 1;
            end
        end
        if (it == 2) begin
            rd1[0] = 1; rd1[1] = 2; rd1[2] = T + 2; rd1[3] = 1;
        end

        fault = BIG; fIdx = 0; done1 = BIG; r = D + 1;
        for (int m = 0; m < N; m++) begin
            if (fault == BIG) begin
                rel1[m] = r;
                if (rd1[m] > T + 1) begin
                    fault = r + T + 1;
                    fIdx  = m;
                end else begin
                    r = r + rd1[m];
                end
            end
        end
        if (fault == BIG) done1 = r;

        doSoft = (fault == BIG) && ($urandom_range(0, 3) != 0);
        if (it == 0 || it == 1 || it == 3) doSoft = 1'b1;
        if (it == 2) doSoft = 1'b0;
        s = BIG; done2 = BIG; kLow = 0; pat = 4'h0;
        if (doSoft) begin
            pat = 4'($urandom_range(1, 15));
            if (it == 0) pat = 4'b0010;
            if (it == 1) pat = 4'b1010;
            if (it == 3) pat = 4'b0001;
            for (int m = N - 1; m >= 0; m--) begin
                if (pat[m]) kLow = m;
            end
            s = done1 + $urandom_range(1, 5);
            r = s + (N - kLow) + D + 1;
            for (int m = kLow; m < N; m++) begin
                set2[m] = s + (N - m);
                if (fault == BIG) begin
                    rel2[m] = r;
                    if (rd2[m] > T + 1) begin
                        fault = r + T + 1;
                        fIdx  = m;
                    end else begin
                        r = r + rd2[m];
                    end
                end
            end
            if (fault == BIG) done2 = r;
        end

        last = (fault < BIG) ? fault : (doSoft ? done2 : done1);
        endE = last + $urandom_range(1, 6);
        if ($urandom_range(0, 4) == 0) endE = $urandom_range(1, last);
        if (it < 3) endE = last + 4;
        if (it == 3) endE = s + 2;

        for (int e = 0; e <= endE; e++) begin
            sysRstReq = (e == 0);
            for (int m = 0; m < N; m++) begin
                int rr, dd;
                if (doSoft && m >= kLow && e > s) begin
                    rr = rel2[m]; dd = rd2[m];
                end else begin
                    rr = rel1[m]; dd = rd1[m];
                end
                if (rr < BIG && e > rr && e < rr + dd) domainRdy[m] = 1'b0;
                else if (rr < BIG && e == rr + dd)    domainRdy[m] = 1'b1;
                else                                  domainRdy[m] = 1'($urandom_range(0, 1));
            end
            if (doSoft && e == s)
                domainRstReq = pat;
            else if ((done1 < BIG && e > done1 && e < s) || (done2 < BIG && e > done2))
                domainRstReq = 4'h0;
            else
                domainRstReq = 4'($urandom_range(0, 15));

            @(posedge clk);
            #1;
            for (int m = 0; m < N; m++) begin
                rstE[m] = (e < rel1[m]) || (e >= set2[m] && e < rel2[m]);
            end
            if (e >= fault) rstE = 4'hF;
            checkVal("domainRst", 32'(domainRst), 32'(rstE));
            checkVal("sysResetDone", 32'(sysResetDone),
                     ((e >= done1 && e < s) || e >= done2) ? 32'd1 : 32'd0);
            checkVal("sysResetError", 32'(sysResetError), (e >= fault) ? 32'd1 : 32'd0);
            checkVal("errorDomain", 32'(errorDomain), (e >= fault) ? 32'(fIdx) : 32'd0);
        end
    endtask

    task automatic runSingle();
        sysRstReq1 = 1'b1; domainRdy1 = 1'b0; domainRstReq1 = 1'b0;
        @(posedge clk);
        #1;
        checkVal("n1_reset_rst", 32'(domainRst1), 32'd1);
        checkVal("n1_reset_done", 32'(sysResetDone1), 32'd0);
        sysRstReq1 = 1'b0;
        for (int e = 1; e <= 5000; e++) begin
            domainRstReq1 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (e == 15) checkVal("n1_hold_rst", 32'(domainRst1), 32'd1);
            if (e == 16) checkVal("n1_release_rst", 32'(domainRst1), 32'd0);
            if (e % 500 == 0) begin
                checkVal("n1_wait_rst", 32'(domainRst1), 32'd0);
                checkVal("n1_wait_done", 32'(sysResetDone1), 32'd0);
                checkVal("n1_no_fault", 32'(sysResetError1), 32'd0);
            end
        end
        domainRstReq1 = 1'b0;
        domainRdy1 = 1'b1;
        @(posedge clk);
        #1;
        checkVal("n1_done", 32'(sysResetDone1), 32'd1);
        domainRstReq1 = 1'b1;
        @(posedge clk);
        #1;
        checkVal("n1_req_done", 32'(sysResetDone1), 32'd0);
        checkVal("n1_req_rst", 32'(domainRst1), 32'd0);
        domainRstReq1 = 1'b0;
        @(posedge clk);
        #1;
        checkVal("n1_shutdown_rst", 32'(domainRst1), 32'd1);
        for (int j = 2; j <= 16; j++) begin
            @(posedge clk);
            #1;
            checkVal("n1_rehold_rst", 32'(domainRst1), 32'd1);
        end
        @(posedge clk);
        #1;
        checkVal("n1_rerelease_rst", 32'(domainRst1), 32'd0);
        checkVal("n1_rerelease_done", 32'(sysResetDone1), 32'd0);
        @(posedge clk);
        #1;
        checkVal("n1_redone", 32'(sysResetDone1), 32'd1);
        checkVal("n1_reerr", 32'(sysResetError1), 32'd0);
    endtask

    initial begin
        sysRstReq = 1'b1; domainRdy = 4'h0; domainRstReq = 4'h0;
        sysRstReq1 = 1'b1; domainRdy1 = 1'b0; domainRstReq1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int it = 0; it < 40; it++) runIter(it);
        runSingle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
